// File: rtl/counter_timer_ctrl.sv
// Command-driven interval timer: a G_WIDTH-bit up-counter sequenced by START/PAUSE/RESUME/STOP
// requests, with terminal-count tick, sticky irq/overrun and an illegal-command error pulse.
module counter_timer_ctrl #(
    parameter int unsigned G_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic               cmd_periodic,
    input  logic [G_WIDTH-1:0] cmd_period,
    output logic [G_WIDTH-1:0] count,
    output logic               busy,
    output logic               tick,
    output logic               irq,
    input  logic               irq_ack,
    output logic               overrun,
    output logic               err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    localparam logic [1:0] OpStart  = 2'd0;
    localparam logic [1:0] OpPause  = 2'd1;
    localparam logic [1:0] OpResume = 2'd2;
    localparam logic [1:0] OpStop   = 2'd3;

    state_e             state_q, state_d;
    logic [G_WIDTH-1:0] count_q, count_d;
    logic [G_WIDTH-1:0] period_q, period_d;
    logic               periodic_q, periodic_d;
    logic               tick_q, tick_d;
    logic               irq_q, irq_d;
    logic               overrun_q, overrun_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               accept;
    logic               step;
    logic [G_WIDTH-1:0] last;

    assign accept = cmd_valid & ready_q;
    assign last   = period_q - 1'b1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;
        step       = 1'b0;

        if (accept) begin
            unique case (cmd_op)
                OpStart: begin
                    if (cmd_period != '0) begin
                        state_d    = StRun;
                        count_d    = '0;
                        period_d   = cmd_period;
                        periodic_d = cmd_periodic;
                    end else begin
                        err_d = 1'b1;
                        step  = (state_q == StRun);
                    end
                end
                OpPause: begin
                    if (state_q == StRun) begin
                        state_d = StPause;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OpResume: begin
                    if (state_q == StPause) begin
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                        step  = (state_q == StRun);
                    end
                end
                OpStop: begin
                    if (state_q == StIdle) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                        count_d = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            step = (state_q == StRun);
        end

        // A rejected command leaves a running timer counting; legal commands pre-empt the step.
        if (step) begin
            if (count_q == last) begin
                tick_d = 1'b1;
                if (periodic_q) begin
                    count_d = '0;
                end else begin
                    state_d = StDone;
                end
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_comb begin
        irq_d     = tick_d | (irq_q & ~irq_ack);
        overrun_d = (tick_d & irq_q & ~irq_ack) | (overrun_q & ~irq_ack);
        ready_d   = ~accept;
        busy_d    = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            overrun_q  <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            overrun_q  <= overrun_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign tick      = tick_q;
    assign irq       = irq_q;
    assign overrun   = overrun_q;
    assign err       = err_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Table-driven bench for counter_timer_ctrl: one vector per clock, expected outputs after the edge.
module tb_counter_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_periodic;
    logic [3:0] cmd_period;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       irq;
    logic       irq_ack;
    logic       overrun;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    counter_timer_ctrl #(.G_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_periodic (cmd_periodic),
        .cmd_period   (cmd_period),
        .count        (count),
        .busy         (busy),
        .tick         (tick),
        .irq          (irq),
        .irq_ack      (irq_ack),
        .overrun      (overrun),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       v;
        logic [1:0] op;
        logic       per;
        logic [3:0] p;
        logic       ack;
        logic [3:0] cnt;
        logic       busy;
        logic       tick;
        logic       irq;
        logic       ovr;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [1:0] START  = 2'd0;
    localparam logic [1:0] PAUSE  = 2'd1;
    localparam logic [1:0] RESUME = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    task automatic add(input logic rst_n, input logic v, input logic [1:0] op, input logic per,
                       input logic [3:0] p, input logic ack, input logic [3:0] cnt,
                       input logic b, input logic t, input logic i, input logic o,
                       input logic e, input logic r);
        vec_t x;
        x.rst_n = rst_n; x.v = v; x.op = op; x.per = per; x.p = p; x.ack = ack;
        x.cnt = cnt; x.busy = b; x.tick = t; x.irq = i; x.ovr = o; x.err = e; x.rdy = r;
        vecs.push_back(x);
    endtask

    // Idle-input row: only the expected outputs vary.
    task automatic idle(input logic ack, input logic [3:0] cnt, input logic b, input logic t,
                        input logic i, input logic o, input logic e, input logic r);
        add(1, 0, 0, 0, 0, ack, cnt, b, t, i, o, e, r);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic v, input logic [1:0] op,
                         input logic per, input logic [3:0] p, input logic ack);
        reset = rst_n; cmd_valid = v; cmd_op = op; cmd_periodic = per; cmd_period = p;
        irq_ack = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_periodic = 1'b0;
        cmd_period = '0; irq_ack = 1'b0;

        // reset held 3 cycles, then released
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // one-shot P=5
        add(1, 1, START, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        idle(0, 2, 1, 0, 0, 0, 0, 1);
        idle(0, 3, 1, 0, 0, 0, 0, 1);
        idle(0, 4, 1, 0, 0, 0, 0, 1);
        idle(0, 4, 0, 1, 1, 0, 0, 1);
        idle(0, 4, 0, 0, 1, 0, 0, 1);
        idle(1, 4, 0, 0, 0, 0, 0, 1);
        // periodic P=3 from DONE, no ack -> overrun
        add(1, 1, START, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        idle(0, 2, 1, 0, 0, 0, 0, 1);
        idle(0, 0, 1, 1, 1, 0, 0, 1);
        idle(0, 1, 1, 0, 1, 0, 0, 1);
        idle(0, 2, 1, 0, 1, 0, 0, 1);
        idle(0, 0, 1, 1, 1, 1, 0, 1);
        idle(0, 1, 1, 0, 1, 1, 0, 1);
        idle(0, 2, 1, 0, 1, 1, 0, 1);
        idle(0, 0, 1, 1, 1, 1, 0, 1);
        idle(1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, STOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // P=6 one-shot with pause at 2
        add(1, 1, START, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        idle(0, 2, 1, 0, 0, 0, 0, 1);
        add(1, 1, PAUSE, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) idle(0, 2, 1, 0, 0, 0, 0, 1);
        add(1, 1, RESUME, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        idle(0, 3, 1, 0, 0, 0, 0, 1);
        idle(0, 4, 1, 0, 0, 0, 0, 1);
        idle(0, 5, 1, 0, 0, 0, 0, 1);
        idle(0, 5, 0, 1, 1, 0, 0, 1);
        idle(1, 5, 0, 0, 0, 0, 0, 1);
        // restart then STOP mid-run
        add(1, 1, START, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        idle(0, 2, 1, 0, 0, 0, 0, 1);
        add(1, 1, STOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // illegal: RESUME in IDLE, START P=0
        add(1, 1, RESUME, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, START, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // PAUSE while paused, then back-to-back command ignored while not ready
        add(1, 1, START, 1, 4, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, PAUSE, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, PAUSE, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, RESUME, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, STOP, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1);
        add(1, 1, STOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // PAUSE on the terminal edge suppresses the tick
        add(1, 1, START, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, PAUSE, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        idle(0, 1, 1, 0, 0, 0, 0, 1);
        add(1, 1, STOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 1);
        // P=1 periodic: tick every cycle; set wins over ack
        add(1, 1, START, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 0, 1, 1, 1, 0, 0, 1);
        idle(0, 0, 1, 1, 1, 1, 0, 1);
        idle(1, 0, 1, 1, 1, 0, 0, 1);
        idle(0, 0, 1, 1, 1, 1, 0, 1);
        add(1, 1, STOP, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        idle(1, 0, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].v, vecs[i].op, vecs[i].per, vecs[i].p, vecs[i].ack);
            chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d.tick", i), 32'(tick), 32'(vecs[i].tick));
            chk($sformatf("v%0d.irq", i), 32'(irq), 32'(vecs[i].irq));
            chk($sformatf("v%0d.overrun", i), 32'(overrun), 32'(vecs[i].ovr));
            chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d.cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].rdy));
        end

        // P=15 periodic: wraps from 14 to 0 with a tick, then reset at count=7
        drive(1, 1, START, 1, 15, 0);
        chk("p15.start_count", 32'(count), 32'd0);
        chk("p15.start_busy", 32'(busy), 32'd1);
        for (int k = 1; k <= 14; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("p15.count%0d", k), 32'(count), 32'(k));
            chk($sformatf("p15.tick%0d", k), 32'(tick), 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("p15.wrap_count", 32'(count), 32'd0);
        chk("p15.wrap_tick", 32'(tick), 32'd1);
        chk("p15.wrap_irq", 32'(irq), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk($sformatf("p15.count2_%0d", k), 32'(count), 32'(k));
            chk($sformatf("p15.tick2_%0d", k), 32'(tick), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_mid.count", 32'(count), 32'd0);
        chk("rst_mid.irq", 32'(irq), 32'd0);
        chk("rst_mid.busy", 32'(busy), 32'd0);
        chk("rst_mid.tick", 32'(tick), 32'd0);
        chk("rst_mid.ready", 32'(cmd_ready), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_rel.ready", 32'(cmd_ready), 32'd1);
        chk("rst_rel.count", 32'(count), 32'd0);
        chk("rst_rel.busy", 32'(busy), 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_idle.count", 32'(count), 32'd0);
        chk("rst_idle.tick", 32'(tick), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
